password_entry_buffer: RTL and testbench
========================================

// Module: password_entry_buffer
// PURPOSE
//   Parametrised keypad entry front-end for the door lock; successor to the fixed 3-digit password getter.
//   Collects N_DIGITS digits of DIGIT_W bits, with backspace, clear, submit, an inactivity timeout and digit validation.
//   Sits between the keypad decoder and the password comparator.
//   All inputs are synchronous to i_clk and debounced upstream.
// PARAMETERS
//   N_DIGITS        3    digits per password (>=1)
//   DIGIT_W         4    bits per digit
//   MAX_DIGIT       9    largest accepted digit value when DECIMAL_ONLY=1
//   DECIMAL_ONLY    1    1: digits > MAX_DIGIT rejected; 0: any DIGIT_W value accepted
//   OVERWRITE       1    1: digit while full shifts in and drops the oldest; 0: digit while full is rejected
//   TIMEOUT_CYCLES  16   idle cycles before a non-empty buffer auto-clears; 0 disables the timeout
// PORTS
//   i_clk         in   1                    clock, rising edge
//   i_reset_n     in   1                    asynchronous, active-low reset
//   i_digit       in   DIGIT_W              digit value, sampled on a confirm event
//   i_confirm     in   1                    level; rising edge = digit event
//   i_backspace   in   1                    level; rising edge = delete newest digit
//   i_enter       in   1                    level; rising edge = submit
//   i_clear       in   1                    level; synchronous clear while high
//   o_password    out  N_DIGITS*DIGIT_W     live buffer; newest digit in the LSBs
//   o_count       out  $clog2(N_DIGITS+1)   digits held
//   o_full        out  1                    o_count == N_DIGITS
//   o_submit_pw   out  N_DIGITS*DIGIT_W     value captured on the last good submit; held until the next one
//   o_submit      out  1                    1-cycle pulse: good submit
//   o_short       out  1                    1-cycle pulse: enter with o_count < N_DIGITS
//   o_reject      out  1                    1-cycle pulse: digit refused (invalid value, or full with OVERWRITE=0)
//   o_timeout     out  1                    1-cycle pulse: buffer auto-cleared after idle time
// BEHAVIOUR
//   - Reset (async assert, sync release): every output and register is 0, except the edge-detect history registers, which reset to 1.
//     A level held high through reset release therefore produces no event.
//   - Edge detect: event = input & ~prev. prev is registered every cycle. The action takes effect at the same edge; outputs are visible the next cycle.
//   - Priority within one cycle: clear > enter > backspace > digit > timeout. Only the highest-priority event acts; lower ones are dropped.
//   - Digit: pw <= {pw[W-DIGIT_W-1:0], i_digit}, where W = N_DIGITS*DIGIT_W. count++ if not full.
//     When full: OVERWRITE=1 shifts in and count stays N_DIGITS; OVERWRITE=0 rejects.
//   - Invalid digit (DECIMAL_ONLY=1 and i_digit > MAX_DIGIT): o_reject pulses; buffer unchanged.
//   - Backspace: pw <= pw >> DIGIT_W, zero-filling the MSBs, and count--. At count 0 it is a no-op (no pulse).
//   - Enter: if full, o_submit_pw <= pw and o_submit pulses. Otherwise o_short pulses. In both cases pw and count clear at the same edge.
//   - Clear: pw and count go to 0; no pulse. Edge history keeps updating during clear.
//   - Timeout: the idle counter resets on any accepted event, on a reject, and while count==0.
//     Otherwise it increments. At TIMEOUT_CYCLES-1 it clears pw and count, pulses o_timeout, and returns to 0.
//     The counter saturates and never wraps.
//   - Async reset mid-entry drops everything, including o_submit_pw.
//   - o_full is combinational from count; every pulse output is registered.
// STRUCTURE
//   - Package password_pkg: DIGIT_W, N_DIGITS, MAX_DIGIT defaults; a pw_t-width helper; cnt width function clog2(N_DIGITS+1).
//   - Sub-module edge_pulse: registered rising-edge detector with reset value 1. Instantiated 3x (confirm, backspace, enter).
//   - Top level: priority decode, shift register, counter, timeout counter, output registers.
// TESTING  (N_DIGITS=3, DIGIT_W=4, TIMEOUT_CYCLES=16, OVERWRITE=1, DECIMAL_ONLY=1)
//   1. Hold i_confirm=1 across reset release -> o_password=12'h000, o_count=0, no events.
//      Then digits 1,2,3 -> 12'h123, count 3, o_full=1.
//   2. Full 12'h123 + digit 4 -> 12'h234, count 3. Rerun with OVERWRITE=0 -> o_reject pulse, 12'h123 kept.
//   3. Digit 4'hA -> o_reject pulse, buffer unchanged.
//      Digits 1,2 + backspace -> 12'h001, count 1. Two more backspaces -> 12'h000, count 0, no pulse.
//   4. Digits 7,8,9 + enter -> o_submit 1 cycle, o_submit_pw=12'h789, o_password=0, count 0.
//      Digit 5 + enter -> o_short pulse, o_submit_pw still 12'h789.
//   5. Digit 6 then idle -> o_timeout pulses exactly 16 cycles after the digit edge; buffer 0.
//      Idle with count 0 -> no pulse ever.
//   6. Confirm and clear rising in the same cycle -> buffer 0, no digit taken.
//      Assert i_reset_n=0 mid-entry (12'h045) -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/password_pkg.sv
// Shared defaults, width helpers and the per-cycle action encoding
// for the keypad password entry buffer.
package password_pkg;

  localparam int DEF_N_DIGITS  = 3;
  localparam int DEF_DIGIT_W   = 4;
  localparam int DEF_MAX_DIGIT = 9;

  // Width of a packed password of n digits, w bits each.
  function automatic int pw_width(input int n, input int w);
    return n * w;
  endfunction

  // Width of a counter that must hold 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  typedef logic [DEF_N_DIGITS*DEF_DIGIT_W-1:0] pw_t;

  // The single action taken at a clock edge after priority resolution.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_CLEAR,
    ACT_ENTER,
    ACT_BACKSPACE,
    ACT_DIGIT,
    ACT_TIMEOUT
  } action_e;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for a synchronous, debounced level input.
// The history register resets to 1 so a level already high when reset
// releases is not mistaken for a fresh press.
module edge_pulse (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;

  // Remember last cycle's level.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (!i_reset_n) r_prev <= 1'b1;
    else            r_prev <= i_level;
  end

  assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/password_entry_buffer.sv
// Keypad entry front-end: collects N_DIGITS digits with backspace, clear,
// submit, digit validation and an inactivity auto-clear. Newest digit is
// held in the least significant digit position of o_password.
module password_entry_buffer
  import password_pkg::*;
#(
  parameter int N_DIGITS       = DEF_N_DIGITS,
  parameter int DIGIT_W        = DEF_DIGIT_W,
  parameter int MAX_DIGIT      = DEF_MAX_DIGIT,
  parameter bit DECIMAL_ONLY   = 1'b1,
  parameter bit OVERWRITE      = 1'b1,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                    i_clk,
  input  logic                                    i_reset_n,
  input  logic [DIGIT_W-1:0]                      i_digit,
  input  logic                                    i_confirm,
  input  logic                                    i_backspace,
  input  logic                                    i_enter,
  input  logic                                    i_clear,
  output logic [pw_width(N_DIGITS, DIGIT_W)-1:0]  o_password,
  output logic [cnt_width(N_DIGITS)-1:0]          o_count,
  output logic                                    o_full,
  output logic [pw_width(N_DIGITS, DIGIT_W)-1:0]  o_submit_pw,
  output logic                                    o_submit,
  output logic                                    o_short,
  output logic                                    o_reject,
  output logic                                    o_timeout
);

  localparam int PW_W   = pw_width(N_DIGITS, DIGIT_W);
  localparam int CNT_W  = cnt_width(N_DIGITS);
  // Idle counter only has to reach TIMEOUT_CYCLES-1.
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(N_DIGITS);

  logic [PW_W-1:0]   r_pw;
  logic [CNT_W-1:0]  r_count;
  logic [PW_W-1:0]   r_submit_pw;
  logic [IDLE_W-1:0] r_idle;
  logic              r_submit;
  logic              r_short;
  logic              r_reject;
  logic              r_timeout;

  logic              w_confirm_ev;
  logic              w_backspace_ev;
  logic              w_enter_ev;
  logic              w_full;
  logic              w_digit_ok;
  logic              w_timeout_hit;
  logic [PW_W-1:0]   w_pw_push;
  logic [PW_W-1:0]   w_pw_pop;
  action_e           w_action;

  edge_pulse u_confirm_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_level   (i_confirm),
    .o_rise    (w_confirm_ev)
  );

  edge_pulse u_backspace_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_level   (i_backspace),
    .o_rise    (w_backspace_ev)
  );

  edge_pulse u_enter_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_level   (i_enter),
    .o_rise    (w_enter_ev)
  );

  assign w_full        = (r_count == FULL_COUNT);
  assign w_digit_ok    = !DECIMAL_ONLY || (i_digit <= DIGIT_W'(MAX_DIGIT));
  assign w_timeout_hit = (TIMEOUT_CYCLES != 0) && (r_count != '0) &&
                         (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));
  // Shift-in drops the oldest digit off the top; shift-out zero-fills it.
  assign w_pw_push     = (r_pw << DIGIT_W) | PW_W'(i_digit);
  assign w_pw_pop      = r_pw >> DIGIT_W;

  // Resolve simultaneous requests: clear > enter > backspace > digit > timeout.
  always_comb begin
    // NOTE: default first so every path assigns w_action and no latch is inferred.
    w_action = ACT_NONE;
    if (i_clear)             w_action = ACT_CLEAR;
    else if (w_enter_ev)     w_action = ACT_ENTER;
    else if (w_backspace_ev) w_action = ACT_BACKSPACE;
    else if (w_confirm_ev)   w_action = ACT_DIGIT;
    else if (w_timeout_hit)  w_action = ACT_TIMEOUT;
  end

  // Buffer, counters, captured password and one-cycle status pulses.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      // NOTE: the captured password is reset too; a reset mid-entry must leave no stale secret.
      r_pw        <= '0;
      r_count     <= '0;
      r_submit_pw <= '0;
      r_idle      <= '0;
      r_submit    <= 1'b0;
      r_short     <= 1'b0;
      r_reject    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_submit  <= 1'b0;
      r_short   <= 1'b0;
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
      r_idle    <= '0;
      unique case (w_action)
        ACT_CLEAR: begin
          r_pw    <= '0;
          r_count <= '0;
        end
        ACT_ENTER: begin
          if (w_full) begin
            r_submit_pw <= r_pw;
            r_submit    <= 1'b1;
          end else begin
            r_short <= 1'b1;
          end
          r_pw    <= '0;
          r_count <= '0;
        end
        ACT_BACKSPACE: begin
          if (r_count != '0) begin
            r_pw    <= w_pw_pop;
            r_count <= r_count - CNT_W'(1);
          end
        end
        ACT_DIGIT: begin
          if (!w_digit_ok || (w_full && !OVERWRITE)) begin
            r_reject <= 1'b1;
          end else begin
            r_pw <= w_pw_push;
            if (!w_full) r_count <= r_count + CNT_W'(1);
          end
        end
        ACT_TIMEOUT: begin
          r_pw      <= '0;
          r_count   <= '0;
          r_timeout <= 1'b1;
        end
        default: begin
          // Idle cycle: count only while digits are held; saturate, never wrap.
          if ((TIMEOUT_CYCLES != 0) && (r_count != '0) && (r_idle != '1))
            r_idle <= r_idle + IDLE_W'(1);
          else if ((TIMEOUT_CYCLES != 0) && (r_count != '0))
            r_idle <= r_idle;
        end
      endcase
    end
  end

  assign o_password  = r_pw;
  assign o_count     = r_count;
  assign o_full      = w_full;
  assign o_submit_pw = r_submit_pw;
  assign o_submit    = r_submit;
  assign o_short     = r_short;
  assign o_reject    = r_reject;
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_password_entry_buffer.sv
// Bench for password_entry_buffer: two instances share inputs, one with
// overwrite-when-full and one rejecting when full. Both are compared every
// cycle against a digit-list model; a vector table and hand sequences pin
// the documented corner cases to constants.
module tb_password_entry_buffer;

  localparam int N  = 3;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit;
  logic       conf, bksp, enter, clr;

  logic [11:0] pw   [2];
  logic [11:0] spw  [2];
  logic [1:0]  cnt  [2];
  logic        full [2];
  logic        sub  [2];
  logic        shrt [2];
  logic        rej  [2];
  logic        tmo  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: an ordered list of held digits, oldest first.
  int          m_dig  [2][N];
  int          m_n    [2];
  int          m_idle [2];
  logic [11:0] m_spw  [2];
  bit          m_sub [2], m_short [2], m_rej [2], m_to [2];
  bit          m_pc [2], m_pb [2], m_pe [2];

  typedef struct {
    bit          c, b, e, x;
    logic [3:0]  d;
    logic [11:0] pw;
    int          n;
    bit          sub, sht, rej;
    logic [11:0] spw;
  } vec_t;

  vec_t tbl [38];

  password_entry_buffer #(
    .N_DIGITS(3), .DIGIT_W(4), .MAX_DIGIT(9), .DECIMAL_ONLY(1'b1),
    .OVERWRITE(1'b1), .TIMEOUT_CYCLES(16)
  ) dut_ow (
    .i_clk(clk), .i_reset_n(rst_n), .i_digit(digit), .i_confirm(conf),
    .i_backspace(bksp), .i_enter(enter), .i_clear(clr),
    .o_password(pw[0]), .o_count(cnt[0]), .o_full(full[0]), .o_submit_pw(spw[0]),
    .o_submit(sub[0]), .o_short(shrt[0]), .o_reject(rej[0]), .o_timeout(tmo[0])
  );

  password_entry_buffer #(
    .N_DIGITS(3), .DIGIT_W(4), .MAX_DIGIT(9), .DECIMAL_ONLY(1'b1),
    .OVERWRITE(1'b0), .TIMEOUT_CYCLES(16)
  ) dut_rj (
    .i_clk(clk), .i_reset_n(rst_n), .i_digit(digit), .i_confirm(conf),
    .i_backspace(bksp), .i_enter(enter), .i_clear(clr),
    .o_password(pw[1]), .o_count(cnt[1]), .o_full(full[1]), .o_submit_pw(spw[1]),
    .o_submit(sub[1]), .o_short(shrt[1]), .o_reject(rej[1]), .o_timeout(tmo[1])
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Password value implied by the held digits, newest in the low nibble.
  function automatic logic [11:0] m_pack(input int k);
    int v = 0;
    for (int i = 0; i < m_n[k]; i++) v = (v * 16 + m_dig[k][i]) % 4096;
    return 12'(v);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_idle[k] = 0; m_spw[k] = '0;
      m_sub[k] = 0; m_short[k] = 0; m_rej[k] = 0; m_to[k] = 0;
      m_pc[k] = 1; m_pb[k] = 1; m_pe[k] = 1;
    end
  endtask

  task automatic model_step(input int k);
    bit ec, eb, ee, ow;
    ow = (k == 0);
    ec = conf  && !m_pc[k];
    eb = bksp  && !m_pb[k];
    ee = enter && !m_pe[k];
    m_sub[k] = 0; m_short[k] = 0; m_rej[k] = 0; m_to[k] = 0;
    if (clr) begin
      m_n[k] = 0;
    end else if (ee) begin
      if (m_n[k] == N) begin
        m_spw[k] = m_pack(k);
        m_sub[k] = 1;
      end else begin
        m_short[k] = 1;
      end
      m_n[k] = 0;
    end else if (eb) begin
      if (m_n[k] > 0) m_n[k] = m_n[k] - 1;
    end else if (ec) begin
      if (int'(digit) > 9 || (m_n[k] == N && !ow)) begin
        m_rej[k] = 1;
      end else if (m_n[k] == N) begin
        for (int i = 0; i < N - 1; i++) m_dig[k][i] = m_dig[k][i+1];
        m_dig[k][N-1] = int'(digit);
      end else begin
        m_dig[k][m_n[k]] = int'(digit);
        m_n[k] = m_n[k] + 1;
      end
    end else if (m_n[k] > 0) begin
      m_idle[k] = m_idle[k] + 1;
      if (m_idle[k] == TO) begin
        m_n[k]  = 0;
        m_to[k] = 1;
      end
    end
    if (clr || ee || eb || ec || m_n[k] == 0) m_idle[k] = 0;
    m_pc[k] = conf; m_pb[k] = bksp; m_pe[k] = enter;
  endtask

  // One clock: advance the model at the edge, compare both DUTs mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("dut%0d o_password", k), 32'(pw[k]),  32'(m_pack(k)));
      check($sformatf("dut%0d o_count", k),    32'(cnt[k]), m_n[k]);
      check($sformatf("dut%0d o_full", k),     32'(full[k]), 32'(m_n[k] == N));
      check($sformatf("dut%0d o_submit_pw", k), 32'(spw[k]), 32'(m_spw[k]));
      check($sformatf("dut%0d o_submit", k),   32'(sub[k]),  32'(m_sub[k]));
      check($sformatf("dut%0d o_short", k),    32'(shrt[k]), 32'(m_short[k]));
      check($sformatf("dut%0d o_reject", k),   32'(rej[k]),  32'(m_rej[k]));
      check($sformatf("dut%0d o_timeout", k),  32'(tmo[k]),  32'(m_to[k]));
    end
  endtask

  task automatic set_in(input bit c, input bit b, input bit e, input bit x, input logic [3:0] d);
    conf = c; bksp = b; enter = e; clr = x; digit = d;
  endtask

  task automatic press_digit(input logic [3:0] d);
    set_in(1, 0, 0, 0, d); tick();
    set_in(0, 0, 0, 0, d); tick();
  endtask

  function automatic vec_t v(input bit c, input bit b, input bit e, input bit x,
                             input logic [3:0] d, input logic [11:0] p, input int n,
                             input bit s, input bit h, input bit r, input logic [11:0] sp);
    vec_t t;
    t.c = c; t.b = b; t.e = e; t.x = x; t.d = d; t.pw = p; t.n = n;
    t.sub = s; t.sht = h; t.rej = r; t.spw = sp;
    return t;
  endfunction

  initial begin
    int lat;
    int seen;
    int burst;

    // Overwrite instance expectations, one row per clock.
    tbl[0]  = v(1,0,0,0,4'h0, 12'h000,0, 0,0,0, 12'h000); // confirm held through reset
    tbl[1]  = v(0,0,0,0,4'h0, 12'h000,0, 0,0,0, 12'h000);
    tbl[2]  = v(1,0,0,0,4'h1, 12'h001,1, 0,0,0, 12'h000);
    tbl[3]  = v(0,0,0,0,4'h1, 12'h001,1, 0,0,0, 12'h000);
    tbl[4]  = v(1,0,0,0,4'h2, 12'h012,2, 0,0,0, 12'h000);
    tbl[5]  = v(0,0,0,0,4'h2, 12'h012,2, 0,0,0, 12'h000);
    tbl[6]  = v(1,0,0,0,4'h3, 12'h123,3, 0,0,0, 12'h000);
    tbl[7]  = v(0,0,0,0,4'h3, 12'h123,3, 0,0,0, 12'h000);
    tbl[8]  = v(1,0,0,0,4'h4, 12'h234,3, 0,0,0, 12'h000); // full: oldest dropped
    tbl[9]  = v(0,0,0,0,4'h4, 12'h234,3, 0,0,0, 12'h000);
    tbl[10] = v(0,0,1,0,4'h0, 12'h000,0, 1,0,0, 12'h234);
    tbl[11] = v(0,0,0,0,4'h0, 12'h000,0, 0,0,0, 12'h234);
    tbl[12] = v(1,0,0,0,4'hA, 12'h000,0, 0,0,1, 12'h234); // invalid digit
    tbl[13] = v(0,0,0,0,4'hA, 12'h000,0, 0,0,0, 12'h234);
    tbl[14] = v(1,0,0,0,4'h1, 12'h001,1, 0,0,0, 12'h234);
    tbl[15] = v(0,0,0,0,4'h1, 12'h001,1, 0,0,0, 12'h234);
    tbl[16] = v(1,0,0,0,4'h2, 12'h012,2, 0,0,0, 12'h234);
    tbl[17] = v(0,0,0,0,4'h2, 12'h012,2, 0,0,0, 12'h234);
    tbl[18] = v(0,1,0,0,4'h0, 12'h001,1, 0,0,0, 12'h234);
    tbl[19] = v(0,0,0,0,4'h0, 12'h001,1, 0,0,0, 12'h234);
    tbl[20] = v(0,1,0,0,4'h0, 12'h000,0, 0,0,0, 12'h234);
    tbl[21] = v(0,0,0,0,4'h0, 12'h000,0, 0,0,0, 12'h234);
    tbl[22] = v(0,1,0,0,4'h0, 12'h000,0, 0,0,0, 12'h234); // backspace when empty
    tbl[23] = v(0,0,0,0,4'h0, 12'h000,0, 0,0,0, 12'h234);
    tbl[24] = v(1,0,0,0,4'h7, 12'h007,1, 0,0,0, 12'h234);
    tbl[25] = v(0,0,0,0,4'h7, 12'h007,1, 0,0,0, 12'h234);
    tbl[26] = v(1,0,0,0,4'h8, 12'h078,2, 0,0,0, 12'h234);
    tbl[27] = v(0,0,0,0,4'h8, 12'h078,2, 0,0,0, 12'h234);
    tbl[28] = v(1,0,0,0,4'h9, 12'h789,3, 0,0,0, 12'h234);
    tbl[29] = v(0,0,0,0,4'h9, 12'h789,3, 0,0,0, 12'h234);
    tbl[30] = v(0,0,1,0,4'h0, 12'h000,0, 1,0,0, 12'h789);
    tbl[31] = v(0,0,0,0,4'h0, 12'h000,0, 0,0,0, 12'h789);
    tbl[32] = v(1,0,0,0,4'h5, 12'h005,1, 0,0,0, 12'h789);
    tbl[33] = v(0,0,0,0,4'h5, 12'h005,1, 0,0,0, 12'h789);
    tbl[34] = v(0,0,1,0,4'h0, 12'h000,0, 0,1,0, 12'h789); // short enter
    tbl[35] = v(0,0,0,0,4'h0, 12'h000,0, 0,0,0, 12'h789);
    tbl[36] = v(1,0,0,1,4'h6, 12'h000,0, 0,0,0, 12'h789); // clear beats digit
    tbl[37] = v(0,0,0,0,4'h6, 12'h000,0, 0,0,0, 12'h789);

    // Reset with confirm held high across release.
    rst_n = 1'b0;
    set_in(1, 0, 0, 0, 4'h0);
    model_reset();
    repeat (3) @(negedge clk);
    check("reset o_password", 32'(pw[0]), 32'h0);
    check("reset o_count",    32'(cnt[0]), 32'h0);
    check("reset o_full",     32'(full[0]), 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 38; i++) begin
      set_in(tbl[i].c, tbl[i].b, tbl[i].e, tbl[i].x, tbl[i].d);
      tick();
      check($sformatf("row%0d o_password", i),  32'(pw[0]),   32'(tbl[i].pw));
      check($sformatf("row%0d o_count", i),     32'(cnt[0]),  tbl[i].n);
      check($sformatf("row%0d o_full", i),      32'(full[0]), 32'(tbl[i].n == N));
      check($sformatf("row%0d o_submit", i),    32'(sub[0]),  32'(tbl[i].sub));
      check($sformatf("row%0d o_short", i),     32'(shrt[0]), 32'(tbl[i].sht));
      check($sformatf("row%0d o_reject", i),    32'(rej[0]),  32'(tbl[i].rej));
      check($sformatf("row%0d o_submit_pw", i), 32'(spw[0]),  32'(tbl[i].spw));
    end

    // Full buffer plus one more digit: overwrite vs reject instance.
    press_digit(4'h1); press_digit(4'h2); press_digit(4'h3);
    set_in(1, 0, 0, 0, 4'h4); tick();
    check("ow full digit pw",     32'(pw[0]),  32'h234);
    check("ow full digit reject", 32'(rej[0]), 32'h0);
    check("rj full digit pw",     32'(pw[1]),  32'h123);
    check("rj full digit reject", 32'(rej[1]), 32'h1);
    check("rj full digit count",  32'(cnt[1]), 32'h3);
    set_in(0, 0, 0, 0, 4'h4); tick();
    check("rj reject one cycle",  32'(rej[1]), 32'h0);
    set_in(0, 0, 1, 0, 4'h0); tick();
    check("ow submit pw", 32'(spw[0]), 32'h234);
    check("rj submit pw", 32'(spw[1]), 32'h123);
    set_in(0, 0, 0, 0, 4'h0); tick();
    check("submit one cycle", 32'(sub[0]), 32'h0);

    // Inactivity timeout: fires on the 16th idle edge after the digit edge.
    set_in(1, 0, 0, 0, 4'h6); tick();
    set_in(0, 0, 0, 0, 4'h6);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (tmo[0]) begin
        lat = k;
        break;
      end
    end
    check("timeout latency",  lat, TO);
    check("timeout clears pw", 32'(pw[0]), 32'h0);
    check("timeout count",     32'(cnt[0]), 32'h0);
    tick();
    check("timeout one cycle", 32'(tmo[0]), 32'h0);
    seen = 0;
    repeat (40) begin
      tick();
      if (tmo[0] || tmo[1]) seen++;
    end
    check("no timeout when empty", seen, 0);

    // Asynchronous reset mid-entry clears outputs without a clock edge.
    press_digit(4'h4); press_digit(4'h5);
    check("pre-reset pw", 32'(pw[0]), 32'h045);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("async rst%0d pw", k),    32'(pw[k]),   32'h0);
      check($sformatf("async rst%0d count", k), 32'(cnt[k]),  32'h0);
      check($sformatf("async rst%0d full", k),  32'(full[k]), 32'h0);
      check($sformatf("async rst%0d spw", k),   32'(spw[k]),  32'h0);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic with occasional idle stretches to exercise timeouts.
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (burst > 0) begin
        set_in(0, 0, 0, 0, 4'($urandom_range(0, 15)));
        burst--;
      end else begin
        if ($urandom_range(0, 99) < 3) burst = $urandom_range(10, 25);
        set_in(1'($urandom_range(0, 1)),
               ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 19) == 0),
               4'($urandom_range(0, 11)));
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
